// File: rtl/fp_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_checker
// Purpose  : Cycle-exact hardware scoreboard for the floating-point ALU bench.
//            Golden results enter a DELAY-stage line so that they line up with
//            the DUT results. Each aligned pair is compared bit for bit. The
//            block keeps per-mode pass/fail statistics and latches the first
//            failure. It can also queue failing entries for readout.
// Ports    : clk, reset, clr            - clock, sync active-high reset/clear
//            exp_valid/mode/r/ex        - golden sample stream
//            act_valid/r/ex             - DUT sample stream
//            pass_cnt, fail_add_cnt,
//            fail_mul_cnt, sample_idx   - statistics
//            first_fail_vld/idx         - first recorded failure
//            align_err                  - sticky valid misalignment flag
//            log_valid/ready/idx/mode/
//            exp/act/ovf                - failure log FIFO read side
// Config   : FP_CHECKER_FAIL_LOG_EN builds the failure log. Without it, the
//            log outputs are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_checker #(
  parameter int WIDTH     = 32,
  parameter int DELAY     = 2,
  parameter int CNT_W     = 16,
  parameter int WARMUP    = 0,
  parameter int LOG_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             exp_valid,
  input  logic             exp_mode,
  input  logic [WIDTH-1:0] exp_r,
  input  logic             exp_ex,
  input  logic             act_valid,
  input  logic [WIDTH-1:0] act_r,
  input  logic             act_ex,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_add_cnt,
  output logic [CNT_W-1:0] fail_mul_cnt,
  output logic [CNT_W-1:0] sample_idx,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             align_err,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [CNT_W-1:0] log_idx,
  output logic             log_mode,
  output logic [WIDTH:0]   log_exp,
  output logic [WIDTH:0]   log_act,
  output logic             log_ovf
);

  localparam logic [CNT_W-1:0] c_warmup_last = CNT_W'(WARMUP) - 1'b1;
  localparam int               c_sup_w       = $clog2(DELAY + 1);
  localparam logic [c_sup_w-1:0] c_sup_init  = c_sup_w'(DELAY);

  logic w_clear;
  assign w_clear = reset | clr;

  // --------------------------------------------------------------------------
  // Golden delay line; only the valid bits need clearing.
  // --------------------------------------------------------------------------
  logic             r_dl_valid [DELAY];
  logic             r_dl_mode  [DELAY];
  logic             r_dl_ex    [DELAY];
  logic [WIDTH-1:0] r_dl_r     [DELAY];

  always_ff @(posedge clk) begin
    r_dl_mode[0] <= exp_mode;
    r_dl_ex[0]   <= exp_ex;
    r_dl_r[0]    <= exp_r;
    for (int i = 1; i < DELAY; i++) begin
      r_dl_mode[i] <= r_dl_mode[i-1];
      r_dl_ex[i]   <= r_dl_ex[i-1];
      r_dl_r[i]    <= r_dl_r[i-1];
    end
    if (w_clear) begin
      for (int i = 0; i < DELAY; i++) r_dl_valid[i] <= 1'b0;
    end else begin
      r_dl_valid[0] <= exp_valid;
      for (int i = 1; i < DELAY; i++) r_dl_valid[i] <= r_dl_valid[i-1];
    end
  end

  logic             w_tap_valid, w_tap_mode, w_tap_ex;
  logic [WIDTH-1:0] w_tap_r;
  assign w_tap_valid = r_dl_valid[DELAY-1];
  assign w_tap_mode  = r_dl_mode[DELAY-1];
  assign w_tap_ex    = r_dl_ex[DELAY-1];
  assign w_tap_r     = r_dl_r[DELAY-1];

  // After a clear, the delay line is empty for DELAY cycles. DUT samples still
  // draining during that window must not be reported as misaligned.
  logic [c_sup_w-1:0] r_sup;
  logic               w_suppress;
  assign w_suppress = (r_sup != '0);

  always_ff @(posedge clk) begin
    if (w_clear)         r_sup <= c_sup_init;
    else if (w_suppress) r_sup <= r_sup - 1'b1;
  end

  // --------------------------------------------------------------------------
  // Compare stage: registers the verdict so statistics land one cycle later.
  // --------------------------------------------------------------------------
  logic           w_pass;
  logic           r_cmp_valid, r_cmp_misalign, r_cmp_pass, r_cmp_mode;
  logic [WIDTH:0] r_cmp_exp, r_cmp_act;

  assign w_pass = (act_r == w_tap_r) && (act_ex == w_tap_ex);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cmp_valid    <= 1'b0;
      r_cmp_misalign <= 1'b0;
    end else begin
      r_cmp_valid    <= w_tap_valid & act_valid;
      r_cmp_misalign <= (w_tap_valid ^ act_valid) & ~w_suppress;
    end
    r_cmp_pass <= w_pass;
    r_cmp_mode <= w_tap_mode;
    r_cmp_exp  <= {w_tap_ex, w_tap_r};
    r_cmp_act  <= {act_ex, act_r};
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  logic             r_warm_done;
  logic [CNT_W-1:0] r_warm_cnt;
  logic [CNT_W-1:0] r_pass, r_fail_add, r_fail_mul, r_sample_idx, r_ff_idx;
  logic             r_ff_vld, r_align_err;
  logic             w_counted, w_fail;

  assign w_counted = r_cmp_valid & r_warm_done;
  assign w_fail    = w_counted & ~r_cmp_pass;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_warm_done  <= (WARMUP == 0);
      r_warm_cnt   <= '0;
      r_pass       <= '0;
      r_fail_add   <= '0;
      r_fail_mul   <= '0;
      r_sample_idx <= '0;
      r_ff_idx     <= '0;
      r_ff_vld     <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      if (r_cmp_valid) begin
        r_sample_idx <= r_sample_idx + 1'b1;
        if (!r_warm_done) begin
          r_warm_cnt <= r_warm_cnt + 1'b1;
          if (r_warm_cnt == c_warmup_last) r_warm_done <= 1'b1;
        end
      end
      if (w_counted && r_cmp_pass && (r_pass != '1))         r_pass     <= r_pass + 1'b1;
      if (w_fail && !r_cmp_mode && (r_fail_add != '1))       r_fail_add <= r_fail_add + 1'b1;
      if (w_fail && r_cmp_mode && (r_fail_mul != '1))        r_fail_mul <= r_fail_mul + 1'b1;
      if (w_fail && !r_ff_vld) begin
        r_ff_vld <= 1'b1;
        r_ff_idx <= r_sample_idx;
      end
      if (r_cmp_misalign) r_align_err <= 1'b1;
    end
  end

  assign pass_cnt       = r_pass;
  assign fail_add_cnt   = r_fail_add;
  assign fail_mul_cnt   = r_fail_mul;
  assign sample_idx     = r_sample_idx;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_idx = r_ff_idx;
  assign align_err      = r_align_err;

  // --------------------------------------------------------------------------
  // Failure log
  // --------------------------------------------------------------------------
`ifdef FP_CHECKER_FAIL_LOG_EN
  localparam int c_ptr_w = $clog2(LOG_DEPTH);
  localparam int c_dat_w = WIDTH + 1;
  localparam int c_ent_w = CNT_W + 1 + 2 * c_dat_w;
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(LOG_DEPTH);

  logic [c_ent_w-1:0] r_mem [LOG_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_ovf;
  logic               w_empty, w_full, w_pop, w_push;
  logic [c_ent_w-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = ~w_empty & log_ready;
  // A pop on the same edge frees a slot, so a full log still takes the write.
  assign w_push  = w_fail & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_sample_idx, r_cmp_mode, r_cmp_exp, r_cmp_act};
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_fail && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Head fields read as 0 while the log is empty.
  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign log_valid = ~w_empty;
  assign log_idx   = w_head[c_ent_w-1 -: CNT_W];
  assign log_mode  = w_head[2*c_dat_w];
  assign log_exp   = w_head[2*c_dat_w-1 -: c_dat_w];
  assign log_act   = w_head[c_dat_w-1:0];
  assign log_ovf   = r_ovf;
`else
  logic w_log_unused;
  assign w_log_unused = ^{log_ready, r_cmp_exp, r_cmp_act};

  assign log_valid = 1'b0;
  assign log_idx   = '0;
  assign log_mode  = 1'b0;
  assign log_exp   = '0;
  assign log_act   = '0;
  assign log_ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_checker
// Purpose  : Directed self-checking bench for fp_result_checker. It uses two
//            instances: one with WARMUP=0 and one with WARMUP=4. Both share the
//            same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_result_checker;

  localparam int W   = 32;
  localparam int DLY = 2;
  localparam int CW  = 16;
  localparam int LD  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clr, exp_valid, exp_mode, exp_ex, act_valid, act_ex, log_ready;
  logic [W-1:0]  exp_r, act_r;
  logic [CW-1:0] pass_cnt, fail_add_cnt, fail_mul_cnt, sample_idx, first_fail_idx, log_idx;
  logic          first_fail_vld, align_err, log_valid, log_mode, log_ovf;
  logic [W:0]    log_exp, log_act;

  logic [CW-1:0] ww_pass, ww_fadd, ww_fmul, ww_idx, ww_ffi, ww_log_idx;
  logic          ww_ffv, ww_align, ww_log_valid, ww_log_mode, ww_log_ovf;
  logic [W:0]    ww_log_exp, ww_log_act;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] g_r [32];
  logic [W-1:0] a_r [32];
  logic         g_ex [32];
  logic         a_ex [32];
  logic         g_mode [32];

  fp_result_checker #(.WIDTH(W), .DELAY(DLY), .CNT_W(CW), .WARMUP(0), .LOG_DEPTH(LD)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .exp_valid(exp_valid), .exp_mode(exp_mode), .exp_r(exp_r), .exp_ex(exp_ex),
    .act_valid(act_valid), .act_r(act_r), .act_ex(act_ex),
    .pass_cnt(pass_cnt), .fail_add_cnt(fail_add_cnt), .fail_mul_cnt(fail_mul_cnt),
    .sample_idx(sample_idx), .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
    .align_err(align_err), .log_valid(log_valid), .log_ready(log_ready), .log_idx(log_idx),
    .log_mode(log_mode), .log_exp(log_exp), .log_act(log_act), .log_ovf(log_ovf)
  );

  fp_result_checker #(.WIDTH(W), .DELAY(DLY), .CNT_W(CW), .WARMUP(4), .LOG_DEPTH(LD)) dut_w (
    .clk(clk), .reset(reset), .clr(clr),
    .exp_valid(exp_valid), .exp_mode(exp_mode), .exp_r(exp_r), .exp_ex(exp_ex),
    .act_valid(act_valid), .act_r(act_r), .act_ex(act_ex),
    .pass_cnt(ww_pass), .fail_add_cnt(ww_fadd), .fail_mul_cnt(ww_fmul),
    .sample_idx(ww_idx), .first_fail_vld(ww_ffv), .first_fail_idx(ww_ffi),
    .align_err(ww_align), .log_valid(ww_log_valid), .log_ready(log_ready), .log_idx(ww_log_idx),
    .log_mode(ww_log_mode), .log_exp(ww_log_exp), .log_act(ww_log_act), .log_ovf(ww_log_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Streams n golden samples and their DUT counterparts DLY cycles later, then
  // idles long enough for the last statistics update to land.
  task automatic run_stream(input int n);
    for (int k = 0; k < n + DLY; k++) begin
      exp_valid = (k < n);
      if (k < n) begin
        exp_r = g_r[k]; exp_ex = g_ex[k]; exp_mode = g_mode[k];
      end
      act_valid = (k >= DLY);
      if (k >= DLY) begin
        act_r = a_r[k-DLY]; act_ex = a_ex[k-DLY];
      end
      step();
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL reset_pass got=%0d exp=0", pass_cnt); end
    checks++; if ({fail_add_cnt, fail_mul_cnt} !== 32'd0) begin errors++; $display("FAIL reset_fail_cnts got=%h exp=0", {fail_add_cnt, fail_mul_cnt}); end
    checks++; if (sample_idx !== 16'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", sample_idx); end
    checks++; if ({first_fail_vld, first_fail_idx, align_err} !== 18'd0) begin errors++; $display("FAIL reset_sticky got=%h exp=0", {first_fail_vld, first_fail_idx, align_err}); end
    checks++; if ({log_valid, log_ovf, log_idx, log_mode, log_exp, log_act} !== '0) begin errors++; $display("FAIL reset_log got=%b/%b idx=%0d exp=0", log_valid, log_ovf, log_idx); end
  endtask

  // One sample: golden at edge t, DUT at t+2, statistics visible after t+3.
  task automatic test_latency();
    do_clear();
    exp_valid = 1'b1; exp_r = 32'h4049_0fdb; exp_ex = 1'b0; exp_mode = 1'b0;
    step();
    exp_valid = 1'b0;
    step();
    act_valid = 1'b1; act_r = 32'h4049_0fdb; act_ex = 1'b0;
    step();
    act_valid = 1'b0;
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL latency_early got=%0d exp=0", pass_cnt); end
    step();
    checks++; if (pass_cnt !== 16'd1) begin errors++; $display("FAIL latency_pass got=%0d exp=1", pass_cnt); end
    checks++; if (sample_idx !== 16'd1) begin errors++; $display("FAIL latency_idx got=%0d exp=1", sample_idx); end
  endtask

  task automatic test_aligned_pass();
    do_clear();
    for (int i = 0; i < 20; i++) begin
      g_r[i] = 32'h3f80_0000 + W'(i * 7); g_ex[i] = 1'b0; g_mode[i] = 1'b0;
      a_r[i] = g_r[i]; a_ex[i] = g_ex[i];
    end
    run_stream(20);
    checks++; if (pass_cnt !== 16'd20) begin errors++; $display("FAIL aligned_pass got=%0d exp=20", pass_cnt); end
    checks++; if ({fail_add_cnt, fail_mul_cnt} !== 32'd0) begin errors++; $display("FAIL aligned_fails got=%h exp=0", {fail_add_cnt, fail_mul_cnt}); end
    checks++; if (sample_idx !== 16'd20) begin errors++; $display("FAIL aligned_idx got=%0d exp=20", sample_idx); end
    checks++; if ({align_err, first_fail_vld, log_valid} !== 3'b000) begin errors++; $display("FAIL aligned_flags got=%b exp=000", {align_err, first_fail_vld, log_valid}); end
  endtask

  task automatic test_mixed_fail();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      g_r[i] = 32'h4000_0000 ^ W'(i << 4); g_ex[i] = i[0]; g_mode[i] = (i >= 5);
      a_r[i] = g_r[i]; a_ex[i] = g_ex[i];
    end
    a_r[3]  = g_r[3] ^ 32'h1;
    a_ex[7] = ~g_ex[7];
    run_stream(10);
    checks++; if (pass_cnt !== 16'd8) begin errors++; $display("FAIL mixed_pass got=%0d exp=8", pass_cnt); end
    checks++; if (fail_add_cnt !== 16'd1) begin errors++; $display("FAIL mixed_fadd got=%0d exp=1", fail_add_cnt); end
    checks++; if (fail_mul_cnt !== 16'd1) begin errors++; $display("FAIL mixed_fmul got=%0d exp=1", fail_mul_cnt); end
    checks++; if ({first_fail_vld, first_fail_idx} !== {1'b1, 16'd3}) begin errors++; $display("FAIL mixed_first got=%b/%0d exp=1/3", first_fail_vld, first_fail_idx); end
    checks++; if (sample_idx !== 16'd10) begin errors++; $display("FAIL mixed_idx got=%0d exp=10", sample_idx); end
`ifdef FP_CHECKER_FAIL_LOG_EN
    checks++; if ({log_valid, log_idx, log_mode} !== {1'b1, 16'd3, 1'b0}) begin errors++; $display("FAIL mixed_log0_hdr got=%b/%0d/%b exp=1/3/0", log_valid, log_idx, log_mode); end
    checks++; if ({log_exp, log_act} !== {g_ex[3], g_r[3], g_ex[3], g_r[3] ^ 32'h1}) begin errors++; $display("FAIL mixed_log0_data got=%h/%h", log_exp, log_act); end
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    checks++; if ({log_valid, log_idx, log_mode} !== {1'b1, 16'd7, 1'b1}) begin errors++; $display("FAIL mixed_log1_hdr got=%b/%0d/%b exp=1/7/1", log_valid, log_idx, log_mode); end
    checks++; if ({log_exp, log_act} !== {g_ex[7], g_r[7], ~g_ex[7], g_r[7]}) begin errors++; $display("FAIL mixed_log1_data got=%h/%h", log_exp, log_act); end
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL mixed_log_empty got=%b exp=0", log_valid); end
`else
    checks++; if ({log_valid, log_ovf, log_idx} !== '0) begin errors++; $display("FAIL mixed_log_off got=%b/%b/%0d exp=0", log_valid, log_ovf, log_idx); end
`endif
  endtask

  // Bitwise compare: signed zeros and NaN payloads must match exactly.
  task automatic test_bitwise();
    do_clear();
    g_r[0] = 32'h0000_0000; a_r[0] = 32'h8000_0000; g_ex[0] = 1'b0; a_ex[0] = 1'b0; g_mode[0] = 1'b0;
    g_r[1] = 32'h7fc0_0001; a_r[1] = 32'h7fc0_0000; g_ex[1] = 1'b1; a_ex[1] = 1'b1; g_mode[1] = 1'b1;
    run_stream(2);
    checks++; if ({pass_cnt, fail_add_cnt, fail_mul_cnt} !== {16'd0, 16'd1, 16'd1}) begin errors++; $display("FAIL bitwise_cnts got=%0d/%0d/%0d exp=0/1/1", pass_cnt, fail_add_cnt, fail_mul_cnt); end
  endtask

  task automatic test_warmup();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      g_r[i] = 32'hc120_0000 + W'(i); g_ex[i] = 1'b0; g_mode[i] = 1'b0;
      a_r[i] = (i < 4) ? (g_r[i] ^ 32'h0000_ffff) : g_r[i]; a_ex[i] = 1'b0;
    end
    run_stream(10);
    checks++; if (ww_pass !== 16'd6) begin errors++; $display("FAIL warm_pass got=%0d exp=6", ww_pass); end
    checks++; if (ww_fadd !== 16'd0) begin errors++; $display("FAIL warm_fadd got=%0d exp=0", ww_fadd); end
    checks++; if (ww_idx !== 16'd10) begin errors++; $display("FAIL warm_idx got=%0d exp=10", ww_idx); end
    checks++; if (ww_ffv !== 1'b0) begin errors++; $display("FAIL warm_ffv got=%b exp=0", ww_ffv); end
    checks++; if ({ww_fmul, ww_ffi, ww_align, ww_log_valid, ww_log_ovf, ww_log_idx, ww_log_mode, ww_log_exp, ww_log_act} !== '0) begin errors++; $display("FAIL warm_rest got=%0d/%0d/%b/%b nonzero", ww_fmul, ww_ffi, ww_align, ww_log_valid); end
    checks++; if ({pass_cnt, fail_add_cnt, first_fail_idx} !== {16'd6, 16'd4, 16'd0}) begin errors++; $display("FAIL nowarm_cnts got=%0d/%0d/%0d exp=6/4/0", pass_cnt, fail_add_cnt, first_fail_idx); end
  endtask

  task automatic test_misalign();
    do_clear();
    step(); step(); step();
    exp_valid = 1'b1; exp_r = 32'h4110_0000; exp_ex = 1'b0; exp_mode = 1'b0;
    step();
    exp_valid = 1'b0;
    act_valid = 1'b1; act_r = 32'h4110_0000; act_ex = 1'b0;
    step();
    act_valid = 1'b0;
    step(); step(); step();
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL misalign_flag got=%b exp=1", align_err); end
    checks++; if ({sample_idx, pass_cnt, fail_add_cnt} !== 48'd0) begin errors++; $display("FAIL misalign_nocmp got=%0d/%0d/%0d exp=0/0/0", sample_idx, pass_cnt, fail_add_cnt); end
    g_r[0] = 32'h4110_0000; a_r[0] = g_r[0]; g_ex[0] = 1'b0; a_ex[0] = 1'b0; g_mode[0] = 1'b0;
    run_stream(1);
    checks++; if ({align_err, sample_idx, pass_cnt} !== {1'b1, 16'd1, 16'd1}) begin errors++; $display("FAIL misalign_after got=%b/%0d/%0d exp=1/1/1", align_err, sample_idx, pass_cnt); end
  endtask

  task automatic test_log_overflow();
    do_clear();
    log_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      g_r[i] = 32'h3f80_0000 + W'(i); g_ex[i] = 1'b0; g_mode[i] = 1'b0;
      a_r[i] = g_r[i] ^ 32'h1; a_ex[i] = 1'b0;
    end
    run_stream(10);
    checks++; if ({fail_add_cnt, pass_cnt, sample_idx} !== {16'd10, 16'd0, 16'd10}) begin errors++; $display("FAIL ovf_cnts got=%0d/%0d/%0d exp=10/0/10", fail_add_cnt, pass_cnt, sample_idx); end
`ifdef FP_CHECKER_FAIL_LOG_EN
    checks++; if ({log_ovf, log_valid} !== 2'b11) begin errors++; $display("FAIL ovf_flag got=%b/%b exp=1/1", log_ovf, log_valid); end
    log_ready = 1'b1;
    for (int i = 0; i < LD; i++) begin
      checks++; if ({log_valid, log_idx} !== {1'b1, CW'(i)}) begin errors++; $display("FAIL ovf_pop%0d got=%b/%0d exp=1/%0d", i, log_valid, log_idx, i); end
      step();
    end
    log_ready = 1'b0;
    checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", log_valid); end
`else
    checks++; if ({log_ovf, log_valid} !== 2'b00) begin errors++; $display("FAIL ovf_off got=%b/%b exp=0/0", log_ovf, log_valid); end
`endif
  endtask

  // Full log with a pop on the same edge as a write: no overflow.
  task automatic test_full_pop_write();
    do_clear();
    log_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      g_r[i] = 32'h4280_0000 + W'(i); g_ex[i] = 1'b0; g_mode[i] = 1'b0;
      a_r[i] = g_r[i] ^ 32'h1; a_ex[i] = 1'b0;
    end
    run_stream(8);
    exp_valid = 1'b1; exp_r = g_r[8]; exp_ex = 1'b0; exp_mode = 1'b0;
    step();
    exp_valid = 1'b0;
    step();
    act_valid = 1'b1; act_r = a_r[8]; act_ex = 1'b0;
    step();
    act_valid = 1'b0;
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    checks++; if (fail_add_cnt !== 16'd9) begin errors++; $display("FAIL fullpop_fadd got=%0d exp=9", fail_add_cnt); end
`ifdef FP_CHECKER_FAIL_LOG_EN
    checks++; if ({log_ovf, log_valid, log_idx} !== {1'b0, 1'b1, 16'd1}) begin errors++; $display("FAIL fullpop_head got=%b/%b/%0d exp=0/1/1", log_ovf, log_valid, log_idx); end
    log_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checks++; if ({log_valid, log_idx} !== {1'b1, CW'(i)}) begin errors++; $display("FAIL fullpop_pop%0d got=%b/%0d exp=1/%0d", i, log_valid, log_idx, i); end
      step();
    end
    log_ready = 1'b0;
    checks++; if ({log_valid, log_ovf} !== 2'b00) begin errors++; $display("FAIL fullpop_end got=%b/%b exp=0/0", log_valid, log_ovf); end
`else
    checks++; if ({log_ovf, log_valid} !== 2'b00) begin errors++; $display("FAIL fullpop_off got=%b/%b exp=0/0", log_ovf, log_valid); end
`endif
  endtask

  task automatic test_clear_midstream();
    do_clear();
    for (int i = 0; i < 3; i++) begin
      g_r[i] = 32'hbf00_0000 + W'(i); g_ex[i] = 1'b0; g_mode[i] = 1'b1;
      a_r[i] = g_r[i]; a_ex[i] = (i == 1);
    end
    run_stream(3);
    checks++; if ({pass_cnt, fail_mul_cnt} !== {16'd2, 16'd1}) begin errors++; $display("FAIL clr_pre got=%0d/%0d exp=2/1", pass_cnt, fail_mul_cnt); end
    exp_valid = 1'b1; exp_r = g_r[0]; exp_ex = 1'b0; exp_mode = 1'b1;
    step();
    exp_r = g_r[1];
    step();
    exp_valid = 1'b0;
    clr = 1'b1;
    act_valid = 1'b1; act_r = g_r[0]; act_ex = 1'b0;
    step();
    clr = 1'b0;
    checks++; if ({pass_cnt, fail_add_cnt, fail_mul_cnt, sample_idx, first_fail_idx} !== 80'd0) begin errors++; $display("FAIL clr_cnts got=%0d/%0d/%0d/%0d/%0d exp=0", pass_cnt, fail_add_cnt, fail_mul_cnt, sample_idx, first_fail_idx); end
    checks++; if ({first_fail_vld, align_err, log_valid, log_ovf, log_idx, log_mode, log_exp, log_act} !== '0) begin errors++; $display("FAIL clr_flags got=%b/%b/%b/%b exp=0", first_fail_vld, align_err, log_valid, log_ovf); end
    act_r = g_r[1];
    step();
    act_valid = 1'b0;
    step(); step(); step();
    checks++; if ({pass_cnt, fail_mul_cnt, sample_idx} !== 48'd0) begin errors++; $display("FAIL clr_inflight got=%0d/%0d/%0d exp=0", pass_cnt, fail_mul_cnt, sample_idx); end
    checks++; if ({align_err, log_valid} !== 2'b00) begin errors++; $display("FAIL clr_align got=%b/%b exp=0/0", align_err, log_valid); end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; log_ready = 1'b0;
    exp_valid = 1'b0; exp_mode = 1'b0; exp_r = '0; exp_ex = 1'b0;
    act_valid = 1'b0; act_r = '0; act_ex = 1'b0;
    test_reset();
    test_latency();
    test_aligned_pass();
    test_mixed_fail();
    test_bitwise();
    test_warmup();
    test_misalign();
    test_log_overflow();
    test_full_pop_write();
    test_clear_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
